// File: rtl/rv_core_pkg.sv
// Shared core definitions for the writeback path.
//   XLEN       : register data width
//   REG_AW     : register address width
//   NUM_REGS   : number of architectural registers (2**REG_AW)
//   wb_entry_t : one pending register write {rd, data}
package rv_core_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned REG_AW   = 5;
   localparam int unsigned NUM_REGS = 2 ** REG_AW;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO buffering long-latency writeback results.
// Ports:
//   clk, reset       : clock, asynchronous active-low reset (flushes pointers/count)
//   push, push_entry : write an entry at the tail (caller guarantees !full)
//   pop, head        : remove the entry shown on head (caller guarantees !empty)
//   empty, full      : occupancy flags
//   count            : number of stored entries, 0..FIFO_DEPTH
module wb_result_fifo
   import rv_core_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          push,
   input  wb_entry_t                     push_entry,
   input  logic                          pop,
   output wb_entry_t                     head,
   output logic                          empty,
   output logic                          full,
   output logic [$clog2(FIFO_DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] FullCnt = (PW + 1)'(FIFO_DEPTH);

   wb_entry_t     mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [PW:0]   count_q;

   assign head  = mem_q[rd_ptr_q];
   assign empty = (count_q == '0);
   assign full  = (count_q == FullCnt);
   assign count = count_q;

   // Storage needs no reset: a flushed FIFO never exposes stale entries.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_entry;
      end
   end

   // Depth is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         if (push && !pop) begin
            count_q <= count_q + (PW + 1)'(1);
         end else if (pop && !push) begin
            count_q <= count_q - (PW + 1)'(1);
         end
      end
   end

endmodule

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: sole driver of the register-file write port.
// Merges single-cycle ALU results (highest priority) with handshaked long-latency results
// (buffered in wb_result_fifo, or bypassed straight through when the FIFO is empty), and keeps
// a pending-destination scoreboard for issue-side hazard detection.
// Ports:
//   clk, reset                      : clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data       : ALU result, no backpressure
//   mem_valid/mem_ready/mem_rd/...  : long-latency result handshake
//   issue_valid/issue_rd            : long-latency op issued, marks rd busy
//   rf_wr_en/rf_wr_addr/rf_wr_data  : registered register-file write port
//   busy_vec                        : pending-write bit per register
//   sb_err                          : sticky scoreboard protocol error
//   stat_bp_cycles                  : backpressure cycle counter (only with WB_ARB_STATS_EN)
// Build option: define WB_ARB_STATS_EN to add the saturating stat_bp_cycles counter.
module wb_write_arbiter
   import rv_core_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                alu_valid,
   input  logic [REG_AW-1:0]   alu_rd,
   input  logic [XLEN-1:0]     alu_data,
   input  logic                mem_valid,
   output logic                mem_ready,
   input  logic [REG_AW-1:0]   mem_rd,
   input  logic [XLEN-1:0]     mem_data,
   input  logic                issue_valid,
   input  logic [REG_AW-1:0]   issue_rd,
   output logic                rf_wr_en,
   output logic [REG_AW-1:0]   rf_wr_addr,
   output logic [XLEN-1:0]     rf_wr_data,
   output logic [NUM_REGS-1:0] busy_vec,
   output logic                sb_err
`ifdef WB_ARB_STATS_EN
   ,
   output logic [15:0]         stat_bp_cycles
`endif
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] FullCnt = CW'(FIFO_DEPTH);

   logic                started_q;
   wb_entry_t           fifo_head;
   logic                fifo_empty;
   logic                fifo_full;
   logic [CW-1:0]       fifo_count;
   logic                fifo_push;
   logic                mem_accept;
   logic                alu_win;
   logic                fifo_win;
   logic                byp_win;
   logic                any_win;
   logic                ll_write;
   logic [REG_AW-1:0]   ll_rd;
   logic                issue_set;
   wb_entry_t           win_entry;
   logic [NUM_REGS-1:0] busy_d;
   logic                err_d;

   // started_q holds mem_ready low while in reset and for the first cycle after release.
   assign mem_ready  = started_q && (fifo_count != FullCnt);
   assign mem_accept = mem_valid && mem_ready;

   assign alu_win  = alu_valid && (alu_rd != '0);
   assign fifo_win = !alu_win && !fifo_empty;
   assign byp_win  = !alu_win && fifo_empty && mem_accept && (mem_rd != '0);
   assign any_win  = alu_win || fifo_win || byp_win;

   // x0 results complete the handshake but are dropped here.
   assign fifo_push = mem_accept && (mem_rd != '0) && !byp_win && !fifo_full;

   assign ll_write  = fifo_win || byp_win;
   assign ll_rd     = fifo_win ? fifo_head.rd : mem_rd;
   assign issue_set = issue_valid && (issue_rd != '0);

   always_comb begin
      win_entry = '{rd: alu_rd, data: alu_data};
      if (fifo_win) begin
         win_entry = fifo_head;
      end else if (byp_win) begin
         win_entry = '{rd: mem_rd, data: mem_data};
      end
   end

   // Scoreboard next state: clear first, then set, so a same-cycle set wins.
   always_comb begin
      busy_d = busy_vec;
      err_d  = 1'b0;
      if (ll_write) begin
         if (!busy_vec[ll_rd]) begin
            err_d = 1'b1;
         end
         busy_d[ll_rd] = 1'b0;
      end
      if (issue_set) begin
         if (busy_vec[issue_rd] && !(ll_write && (ll_rd == issue_rd))) begin
            err_d = 1'b1;
         end
         busy_d[issue_rd] = 1'b1;
      end
      if (alu_win && busy_vec[alu_rd]) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         started_q  <= 1'b0;
         rf_wr_en   <= 1'b0;
         rf_wr_addr <= '0;
         rf_wr_data <= '0;
         busy_vec   <= '0;
         sb_err     <= 1'b0;
      end else begin
         started_q <= 1'b1;
         rf_wr_en  <= any_win;
         if (any_win) begin
            rf_wr_addr <= win_entry.rd;
            rf_wr_data <= win_entry.data;
         end
         busy_vec <= busy_d;
         if (err_d) begin
            sb_err <= 1'b1;
         end
      end
   end

`ifdef WB_ARB_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_bp_cycles <= '0;
      end else if (mem_valid && !mem_ready && (stat_bp_cycles != 16'hFFFF)) begin
         stat_bp_cycles <= stat_bp_cycles + 16'd1;
      end
   end
`endif

   wb_result_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (fifo_push),
      .push_entry ('{rd: mem_rd, data: mem_data}),
      .pop        (fifo_win),
      .head       (fifo_head),
      .empty      (fifo_empty),
      .full       (fifo_full),
      .count      (fifo_count)
   );

endmodule
